// File: rtl/morse_symbol_capture.sv
// Morse key capture: turns a debounced key level into dot/dash symbols per
// letter, flags letter completion, word gaps and per-letter overflow.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no letter in progress, last letter (if any) fully closed
// PRESS     | key held, press_cnt counts the press length
// GAP       | key released inside a letter, gap_cnt counts idle cycles
// WORD_WAIT | letter reported, gap_cnt keeps counting toward a word gap
module morse_symbol_capture #(
  parameter int MAX_SYMBOLS = 5,
  parameter int DASH_TICKS  = 2,
  parameter int LETTER_GAP  = 3,
  parameter int WORD_GAP    = 7,
  parameter int CNT_W       = 8,
  localparam int SCW        = $clog2(MAX_SYMBOLS + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     button,
  output logic [2*MAX_SYMBOLS-1:0] symbols,
  output logic [SCW-1:0]           symbol_count,
  output logic                     letter_valid,
  output logic                     word_gap,
  output logic                     overflow,
  output logic                     busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS     = 2'd1,
    GAP       = 2'd2,
    WORD_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] DASH_LIM    = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] LETTER_LIM  = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WORD_LIM    = CNT_W'(WORD_GAP);
  localparam logic [SCW-1:0]   SLOTS_FULL  = SCW'(MAX_SYMBOLS);

  state_t           state;
  logic [CNT_W-1:0] press_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [1:0]       code;

  // Classification of the press that is ending on this edge.
  always_comb begin
    code = (press_cnt >= DASH_LIM) ? 2'b10 : 2'b01;
  end

  // Sequencer: state, counters, symbol storage and registered pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      press_cnt    <= '0;
      gap_cnt      <= '0;
      symbols      <= '0;
      symbol_count <= '0;
      overflow     <= 1'b0;
      letter_valid <= 1'b0;
      word_gap     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      letter_valid <= 1'b0;
      word_gap     <= 1'b0;
      case (state)
        IDLE, WORD_WAIT: begin
          if (button) begin
            symbols      <= '0;
            symbol_count <= '0;
            overflow     <= 1'b0;
            press_cnt    <= CNT_W'(1);
            state        <= PRESS;
            busy         <= 1'b1;
          end else if (state == WORD_WAIT) begin
            gap_cnt <= gap_cnt + 1'b1;
            if (gap_cnt + 1'b1 == WORD_LIM) begin
              word_gap <= 1'b1;
              state    <= IDLE;
              busy     <= 1'b0;
            end
          end
        end
        PRESS: begin
          if (button) begin
            if (press_cnt != CNT_MAX) press_cnt <= press_cnt + 1'b1;
          end else begin
            if (symbol_count == SLOTS_FULL) begin
              overflow <= 1'b1;
            end else begin
              symbols[2*int'(symbol_count) +: 2] <= code;
              symbol_count <= symbol_count + 1'b1;
            end
            gap_cnt <= CNT_W'(1);
            // A one-cycle letter gap closes the letter on the release edge.
            if (LETTER_LIM == CNT_W'(1)) begin
              letter_valid <= 1'b1;
              state        <= WORD_WAIT;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (button) begin
            press_cnt <= CNT_W'(1);
            state     <= PRESS;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            if (gap_cnt + 1'b1 == LETTER_LIM) begin
              letter_valid <= 1'b1;
              state        <= WORD_WAIT;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_morse_symbol_capture.sv
// Bench for morse_symbol_capture: directed Morse patterns plus random keying,
// every cycle compared against a run-length model of the keying rules.
module tb_morse_symbol_capture;
  localparam int MAXS = 5;
  localparam int DASH = 2;
  localparam int LG   = 3;
  localparam int WG   = 7;
  localparam int SCW  = $clog2(MAXS + 1);

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              button = 1'b0;
  logic [2*MAXS-1:0] symbols;
  logic [SCW-1:0]    symbol_count;
  logic              letter_valid, word_gap, overflow, busy;

  int errors = 0;
  int checks = 0;

  morse_symbol_capture #(
    .MAX_SYMBOLS(MAXS), .DASH_TICKS(DASH), .LETTER_GAP(LG),
    .WORD_GAP(WG), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .button(button),
    .symbols(symbols), .symbol_count(symbol_count),
    .letter_valid(letter_valid), .word_gap(word_gap),
    .overflow(overflow), .busy(busy)
  );

  always #5 clock = ~clock;

  // Model: the letter is a list of codes; key activity is tracked as run lengths.
  int m_q[$];
  bit m_ovf, m_lv, m_wg, m_pressing, m_open, m_wait;
  int m_plen, m_idle;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_ovf = 0; m_lv = 0; m_wg = 0;
    m_pressing = 0; m_open = 0; m_wait = 0;
    m_plen = 0; m_idle = 0;
  endtask

  task automatic model_step(input bit b);
    m_lv = 0;
    m_wg = 0;
    if (b) begin
      if (m_pressing) m_plen++;
      else begin
        if (!m_open) begin
          m_q.delete();
          m_ovf = 0;
        end
        m_open = 1; m_wait = 0; m_pressing = 1; m_plen = 1;
      end
    end else if (m_pressing) begin
      m_pressing = 0;
      if (m_q.size() < MAXS) m_q.push_back((m_plen >= DASH) ? 2 : 1);
      else m_ovf = 1;
      m_idle = 1;
      if (m_idle == LG) begin m_lv = 1; m_open = 0; m_wait = 1; end
    end else if (m_open) begin
      m_idle++;
      if (m_idle == LG) begin m_lv = 1; m_open = 0; m_wait = 1; end
    end else if (m_wait) begin
      m_idle++;
      if (m_idle == WG) begin m_wg = 1; m_wait = 0; end
    end
  endtask

  task automatic check_all(input string where);
    logic [2*MAXS-1:0] exp_sym;
    exp_sym = '0;
    foreach (m_q[i]) exp_sym[2*i +: 2] = 2'(m_q[i]);
    check_val({where, ":symbols"}, 32'(symbols), 32'(exp_sym));
    check_val({where, ":count"}, 32'(symbol_count), 32'(m_q.size()));
    check_val({where, ":overflow"}, 32'(overflow), 32'(m_ovf));
    check_val({where, ":letter_valid"}, 32'(letter_valid), 32'(m_lv));
    check_val({where, ":word_gap"}, 32'(word_gap), 32'(m_wg));
    check_val({where, ":busy"}, 32'(busy), 32'(m_open || m_wait));
  endtask

  task automatic run(input bit b, input int n, input string where);
    for (int k = 0; k < n; k++) begin
      button = b;
      @(posedge clock);
      #1;
      model_step(b);
      check_all(where);
    end
  endtask

  task automatic async_reset(input string where);
    reset = 1'b0;
    #1;
    model_reset();
    check_all(where);
    @(posedge clock);
    @(posedge clock);
    #1;
    check_all(where);
    reset = 1'b1;
  endtask

  int pulses_lv;
  int pulses_wg;
  always @(posedge clock) begin
    if (letter_valid) pulses_lv++;
    if (word_gap) pulses_wg++;
  end

  initial begin
    pulses_lv = 0;
    pulses_wg = 0;
    model_reset();
    #1;
    check_all("reset_hold");
    #12;
    reset = 1'b1;

    // "T": a single long press
    run(1, 3, "T");
    run(0, 1, "T_rel");
    check_val("T_slot0", 32'(symbols[1:0]), 32'h2);
    run(0, 9, "T_tail");

    // "S": three one-cycle presses
    run(1, 1, "S"); run(0, 1, "S"); run(1, 1, "S"); run(0, 1, "S"); run(1, 1, "S");
    run(0, 3, "S_gap");
    check_val("S_symbols", 32'(symbols), 32'h015);
    run(0, 6, "S_tail");

    // Dot/dash boundary
    run(1, 2, "B2"); run(0, 1, "B2");
    check_val("B2_dash", 32'(symbols[1:0]), 32'h2);
    run(0, 7, "B2_tail");

    // Overflow: six dots
    pulses_lv = 0;
    for (int i = 0; i < 6; i++) begin
      run(1, 1, "OVF");
      run(0, 1, "OVF");
    end
    run(0, 8, "OVF_tail");
    check_val("OVF_pulses", 32'(pulses_lv), 32'd1);
    check_val("OVF_count", 32'(symbol_count), 32'd5);
    check_val("OVF_flag", 32'(overflow), 32'd1);

    // "E" then a word gap, then a press during WORD_WAIT
    pulses_wg = 0;
    run(1, 1, "E"); run(0, 9, "E_word");
    check_val("E_wg_pulses", 32'(pulses_wg), 32'd1);
    pulses_wg = 0;
    run(1, 1, "E2"); run(0, 4, "E2_wait"); run(1, 2, "E2_new"); run(0, 3, "E2_lv");
    check_val("E2_no_wg", 32'(pulses_wg), 32'd0);
    run(0, 5, "E2_tail");

    // Reset during the second press of "S"
    run(1, 1, "RST"); run(0, 1, "RST"); button = 1'b1; @(posedge clock); #2;
    async_reset("RST_mid");
    pulses_lv = 0;
    pulses_wg = 0;
    run(0, 20, "RST_after");
    check_val("RST_no_lv", 32'(pulses_lv), 32'd0);
    check_val("RST_no_wg", 32'(pulses_wg), 32'd0);

    // Random keying
    for (int i = 0; i < 500; i++) begin
      run(1, $urandom_range(1, 4), "RND_hi");
      run(0, $urandom_range(1, 9), "RND_lo");
      if ($urandom_range(0, 49) == 0) async_reset("RND_rst");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/morse_symbol_capture.md
MORSE_SYMBOL_CAPTURE -- requirements
Module: morse_symbol_capture

Interface
REQ-001 SHALL have parameter MAX_SYMBOLS, default 5, giving the maximum symbols stored per letter (legal range 1..8).
REQ-002 SHALL have parameter DASH_TICKS, default 2: a press of at least this many cycles is a dash (legal value >=1).
REQ-003 SHALL have parameter LETTER_GAP, default 3: the number of idle cycles that ends a letter.
REQ-004 SHALL have parameter WORD_GAP, default 7: the number of idle cycles that ends a word. The constraint is LETTER_GAP < WORD_GAP <= 2^CNT_W-1.
REQ-005 SHALL have parameter CNT_W, default 8, giving the press and gap counter width.
REQ-006 SHALL have port clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port button, input, 1 bit: key level, active high, already synchronous and debounced.
REQ-009 SHALL have port symbols, output, 2*MAX_SYMBOLS bits: symbol i is at bits [2i+1:2i], with i=0 the first keyed. Codes: 00 empty, 01 dot, 10 dash; 11 is never driven.
REQ-010 SHALL have port symbol_count, output, $clog2(MAX_SYMBOLS+1) bits: the number of stored symbols.
REQ-011 SHALL have port letter_valid, output, 1 bit: a one-cycle pulse when a letter completes.
REQ-012 SHALL have port word_gap, output, 1 bit: a one-cycle pulse when a word gap is detected.
REQ-013 SHALL have port overflow, output, 1 bit: set when more than MAX_SYMBOLS symbols are keyed in the current letter.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 SHALL sample button once per rising edge. A "high edge" is an edge where button=1; a "low edge" is an edge where button=0.
REQ-016 SHALL implement FSM states IDLE, PRESS, GAP and WORD_WAIT; all outputs are registered.
REQ-017 In IDLE or WORD_WAIT, a high edge SHALL clear symbols, symbol_count and overflow, set press_cnt=1, and enter PRESS. This starts a new letter.
REQ-018 In PRESS:
- A high edge SHALL increment press_cnt, saturating at 2^CNT_W-1.
- A low edge SHALL classify the press: dash if press_cnt>=DASH_TICKS, else dot.
- On that low edge it SHALL write the symbol to slot symbol_count, increment symbol_count, set gap_cnt=1, and enter GAP.
REQ-019 On the classifying edge, if symbol_count==MAX_SYMBOLS, the symbol SHALL be dropped and overflow set to 1; symbols and symbol_count are unchanged.
REQ-020 In GAP:
- A high edge SHALL set press_cnt=1 and enter PRESS (same letter).
- A low edge SHALL increment gap_cnt.
- When gap_cnt becomes LETTER_GAP, the block SHALL assert letter_valid for exactly the following cycle and enter WORD_WAIT.
REQ-021 In WORD_WAIT:
- A low edge SHALL increment gap_cnt.
- When gap_cnt becomes WORD_GAP, the block SHALL assert word_gap for exactly one cycle and enter IDLE.
REQ-022 symbols, symbol_count and overflow SHALL hold stable from letter_valid until the next letter starts (REQ-017).
REQ-023 Simultaneous events: in GAP, a high edge takes priority over gap expiry, so no letter_valid is raised. In WORD_WAIT, a high edge takes priority over word expiry, so no word_gap is raised.
REQ-024 letter_valid and word_gap SHALL never be high in the same cycle. letter_valid SHALL fire at most once per letter.
REQ-025 A letter that overflows SHALL still complete with letter_valid=1 and overflow=1.

Reset
REQ-026 While reset=0, the block SHALL asynchronously force:
- FSM to IDLE and press_cnt=gap_cnt=0;
- symbols=0, symbol_count=0, overflow=0;
- letter_valid=0, word_gap=0, busy=0.
REQ-027 A reset asserted mid-press or mid-gap SHALL discard the partial letter; no letter_valid follows reset release.
REQ-028 After reset releases, the first high edge SHALL be treated as the start of a new letter.

Verification (default parameters)
REQ-029 "T": three high edges, then low. Expected:
- after the first low edge: symbols[1:0]=10, symbol_count=1;
- letter_valid=1 for one cycle after the third low edge.
REQ-030 "S": high/low/high/low/high, then low. Expected: symbols=00_00_01_01_01 (binary), symbol_count=3, a single letter_valid pulse.
REQ-031 Boundary: a 1-cycle press stores 01; a 2-cycle press stores 10.
REQ-032 Overflow: six 1-cycle dots separated by 1-cycle gaps. Expected: symbol_count=5, overflow=1, letter_valid pulses once.
REQ-033 Word gap: after "E", hold low. Expected:
- letter_valid after the third low edge;
- word_gap pulses once after the seventh low edge;
- busy=0 afterwards.
A new press during WORD_WAIT clears symbols with no word_gap.
REQ-034 Reset mid-op: reset=0 during the second press of "S". Expected: all outputs are 0 immediately. After release with button low for 20 cycles: no letter_valid and no word_gap.
